dmem_responder: RTL and testbench

- Data-memory responder for the HKALM pipelined RV32 core. It is the memory-side end of the core's data port (address = ALUResult, WriteData, MemWrite, load strobe).
- Serves word loads and stores from an on-chip synchronous RAM with fixed 1-cycle read latency, timed to the core's M→W stage boundary.
- Also decodes a small MMIO window: a 64-bit cycle counter with coherent high-half snapshot, a store counter, and a GPIO output register. Misaligned accesses are flagged.

---
 rtl/dmem_responder_if.sv | 11 +
 rtl/dmem_responder.sv | 101 ++++++++++
 tb/tb_dmem_responder.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/dmem_responder_if.sv
// Core data-port bundle between the HKALM pipeline (master) and the data-memory responder (slave).
interface dmem_responder_if;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] ALUResult;
    logic [31:0] WriteData;
    logic [31:0] ReadData;

    modport master (output MemRead, MemWrite, ALUResult, WriteData, input ReadData);
    modport slave  (input MemRead, MemWrite, ALUResult, WriteData, output ReadData);
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: word RAM with 1-cycle registered reads, plus an MMIO window at 0xFFFF_0000
// holding a 64-bit cycle counter (coherent high snapshot), a store counter and a GPIO register.
module dmem_responder #(
    parameter int DEPTH     = 1024,
    parameter int AW        = 10,
    parameter     INIT_FILE = ""
) (
    input  logic                clk,
    input  logic                reset,
    dmem_responder_if.slave     bus,
    output logic [31:0]         gpio_out,
    output logic                misalign_err
);

    logic [31:0] mem [DEPTH];

    logic          is_mmio;
    logic          aligned;
    logic          rd_ok;
    logic          wr_ok;
    logic [AW-1:0] idx;
    logic [15:0]   off;

    assign is_mmio = (bus.ALUResult[31:16] == 16'hFFFF);
    assign aligned = (bus.ALUResult[1:0] == 2'b00);
    assign idx     = bus.ALUResult[AW+1:2];
    assign off     = bus.ALUResult[15:0];
    assign rd_ok   = bus.MemRead && aligned;
    assign wr_ok   = bus.MemWrite && aligned;

    // RAM is not reset-controlled; non-blocking read gives read-before-write on a same-cycle store.
    logic [31:0] ram_rd_q;
    always_ff @(posedge clk) begin
        if (wr_ok && !is_mmio) begin
            mem[idx] <= bus.WriteData;
        end
        if (bus.MemRead) begin
            ram_rd_q <= mem[idx];
        end
    end

    logic [63:0] cyc_q,     cyc_d;
    logic [31:0] snap_q,    snap_d;
    logic [31:0] stores_q,  stores_d;
    logic [31:0] gpio_q,    gpio_d;
    logic        err_q,     err_d;
    logic        sel_ram_q, sel_ram_d;
    logic [31:0] mmio_rd_q, mmio_rd_d;
    logic [31:0] mmio_rd;

    always_comb begin
        mmio_rd = '0;
        case (off)
            16'h0000: mmio_rd = cyc_q[31:0];
            16'h0004: mmio_rd = snap_q;
            16'h0008: mmio_rd = stores_q;
            16'h000C: mmio_rd = gpio_q;
            default:  mmio_rd = '0;
        endcase
    end

    always_comb begin
        cyc_d     = cyc_q + 64'd1;
        snap_d    = (rd_ok && is_mmio && off == 16'h0000) ? cyc_q[63:32] : snap_q;
        stores_d  = wr_ok ? stores_q + 32'd1 : stores_q;
        gpio_d    = (wr_ok && is_mmio && off == 16'h000C) ? bus.WriteData : gpio_q;
        err_d     = err_q | ((bus.MemRead | bus.MemWrite) & ~aligned);
        sel_ram_d = sel_ram_q;
        mmio_rd_d = mmio_rd_q;
        // Misaligned loads select the MMIO path with a zero value.
        if (bus.MemRead) begin
            sel_ram_d = aligned && !is_mmio;
            mmio_rd_d = (rd_ok && is_mmio) ? mmio_rd : 32'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cyc_q     <= '0;
            snap_q    <= '0;
            stores_q  <= '0;
            gpio_q    <= '0;
            err_q     <= 1'b0;
            sel_ram_q <= 1'b0;
            mmio_rd_q <= '0;
        end else begin
            cyc_q     <= cyc_d;
            snap_q    <= snap_d;
            stores_q  <= stores_d;
            gpio_q    <= gpio_d;
            err_q     <= err_d;
            sel_ram_q <= sel_ram_d;
            mmio_rd_q <= mmio_rd_d;
        end
    end

    assign bus.ReadData = sel_ram_q ? ram_rd_q : mmio_rd_q;
    assign gpio_out     = gpio_q;
    assign misalign_err = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized bench for dmem_responder against a word-array/counter reference model.
module tb_dmem_responder;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] gpio_out;
    logic        misalign_err;

    always #5 clk = ~clk;

    dmem_responder_if bus ();

    dmem_responder #(.DEPTH(1024), .AW(10), .INIT_FILE("")) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus),
        .gpio_out     (gpio_out),
        .misalign_err (misalign_err)
    );

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] m_mem [1024];
    logic [63:0] m_cyc    = '0;
    logic [31:0] m_snap   = '0;
    logic [31:0] m_stores = '0;
    logic [31:0] m_gpio   = '0;
    logic [31:0] m_rdata  = '0;
    logic        m_err    = 1'b0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // One bus cycle: drive at negedge, advance the model by the same clock edge, check after it.
    task automatic cycle(input string tag, input bit rst, input bit rd, input bit wr,
                         input logic [31:0] addr, input logic [31:0] data);
        logic [31:0] rv;
        bit          al;
        bit          mm;
        @(negedge clk);
        reset         = rst;
        bus.MemRead   = rd;
        bus.MemWrite  = wr;
        bus.ALUResult = addr;
        bus.WriteData = data;
        al = (addr[1:0] == 2'b00);
        mm = (addr[31:16] == 16'hFFFF);
        rv = 32'd0;
        if (al && mm) begin
            case (addr[15:0])
                16'h0000: rv = m_cyc[31:0];
                16'h0004: rv = m_snap;
                16'h0008: rv = m_stores;
                16'h000C: rv = m_gpio;
                default:  rv = 32'd0;
            endcase
        end else if (al) begin
            rv = m_mem[addr[11:2]];
        end
        if (rst)      m_rdata = 32'd0;
        else if (rd)  m_rdata = rv;
        if (!rst && rd && addr == 32'hFFFF_0000) m_snap = m_cyc[63:32];
        if (wr && al && !mm) m_mem[addr[11:2]] = data;
        if (!rst && wr && al) begin
            m_stores = m_stores + 32'd1;
            if (addr == 32'hFFFF_000C) m_gpio = data;
        end
        m_err = rst ? 1'b0 : (m_err | ((rd | wr) & ~al));
        m_cyc = rst ? 64'd0 : m_cyc + 64'd1;
        if (rst) begin
            m_stores = '0;
            m_gpio   = '0;
            m_snap   = '0;
        end
        @(posedge clk);
        #1;
        chk({tag, ".rdata"}, {32'd0, bus.ReadData}, {32'd0, m_rdata});
        chk({tag, ".gpio"},  {32'd0, gpio_out},     {32'd0, m_gpio});
        chk({tag, ".err"},   {63'd0, misalign_err}, {63'd0, m_err});
    endtask

    task automatic idle(input string tag);
        cycle(tag, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    // Presets the DUT counter; the next edge increments from v.
    task automatic set_cyc(input logic [63:0] v);
        force dut.cyc_q = v;
        release dut.cyc_q;
        m_cyc = v;
    endtask

    initial begin
        reset = 1'b1;
        bus.MemRead = 1'b0;
        bus.MemWrite = 1'b0;
        bus.ALUResult = '0;
        bus.WriteData = '0;
        for (int i = 0; i < 1024; i++) m_mem[i] = '0;

        cycle("rst0", 1, 0, 0, 32'h0, 32'h0);
        cycle("rst1", 1, 0, 0, 32'h0, 32'h0);

        cycle("st10",   0, 0, 1, 32'h0000_0010, 32'hDEAD_BEEF);
        cycle("ld10",   0, 1, 0, 32'h0000_0010, 32'h0);
        cycle("stores", 0, 1, 0, 32'hFFFF_0008, 32'h0);
        idle("hold");

        cycle("st0",    0, 0, 1, 32'h0000_0000, 32'h1111_1111);
        cycle("alias",  0, 1, 0, 32'h0000_1000, 32'h0);

        cycle("gpio_w", 0, 0, 1, 32'hFFFF_000C, 32'h0000_005A);
        cycle("gpio_r", 0, 1, 0, 32'hFFFF_000C, 32'h0);

        cycle("st20",   0, 0, 1, 32'h0000_0020, 32'h1234_5678);
        cycle("mis_st", 0, 0, 1, 32'h0000_0022, 32'hFFFF_FFFF);
        cycle("ld20",   0, 1, 0, 32'h0000_0020, 32'h0);
        cycle("mis_ld", 0, 1, 0, 32'h0000_0022, 32'h0);
        cycle("stores2",0, 1, 0, 32'hFFFF_0008, 32'h0);
        idle("sticky");

        cycle("st40",   0, 0, 1, 32'h0000_0040, 32'h0000_000A);
        cycle("rw40",   0, 1, 1, 32'h0000_0040, 32'h0000_000B);
        cycle("ld40",   0, 1, 0, 32'h0000_0040, 32'h0);
        cycle("rw_stc", 0, 1, 1, 32'hFFFF_0008, 32'h0);
        cycle("ro_chk", 0, 1, 0, 32'hFFFF_0008, 32'h0);
        cycle("oth_w",  0, 0, 1, 32'hFFFF_0010, 32'h7);
        cycle("oth_r",  0, 1, 0, 32'hFFFF_0010, 32'h0);

        set_cyc(64'h0000_0000_FFFF_FFF0);
        cycle("cyc_lo", 0, 1, 0, 32'hFFFF_0000, 32'h0);
        for (int i = 0; i < 40; i++) idle("wait40");
        cycle("cyc_hi", 0, 1, 0, 32'hFFFF_0004, 32'h0);
        cycle("cyc_lo2",0, 1, 0, 32'hFFFF_0000, 32'h0);
        cycle("cyc_hi2",0, 1, 0, 32'hFFFF_0004, 32'h0);
        set_cyc(64'hFFFF_FFFF_FFFF_FFFE);
        idle("wrap");
        cycle("wrap_lo",0, 1, 0, 32'hFFFF_0000, 32'h0);
        cycle("wrap_hi",0, 1, 0, 32'hFFFF_0004, 32'h0);

        cycle("gpio_w2",0, 0, 1, 32'hFFFF_000C, 32'hABCD_0001);
        cycle("rst_gp", 1, 0, 1, 32'hFFFF_000C, 32'h0000_0077);
        cycle("rst_ram",1, 0, 1, 32'h0000_0080, 32'hCAFE_F00D);
        idle("post_rst");
        cycle("ld80",   0, 1, 0, 32'h0000_0080, 32'h0);
        cycle("stc_rst",0, 1, 0, 32'hFFFF_0008, 32'h0);

        for (int i = 0; i < 32; i++)
            cycle("init", 0, 0, 1, i * 4, $urandom);

        for (int i = 0; i < 400; i++) begin
            logic [31:0] a;
            bit          rd;
            bit          wr;
            bit          rst;
            rd  = ($urandom_range(0, 2) != 0);
            wr  = ($urandom_range(0, 2) == 0);
            rst = ($urandom_range(0, 149) == 0);
            if ($urandom_range(0, 3) == 0)
                a = 32'hFFFF_0000 | ($urandom_range(0, 5) << 2);
            else
                a = ($urandom_range(0, 31) << 2) | (($urandom & 32'h7FFF) << 12);
            if ($urandom_range(0, 15) == 0)
                a = a | $urandom_range(1, 3);
            cycle("rand", rst, rd, wr, a, $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
